// File: rtl/usb_pkt_tx.sv
// Device-side USB packet transmitter: [SYNC] PID [payload CRC16] as a backpressured byte stream.
// Define USB_TX_SYNC_EN to prefix every packet with a 0x80 SYNC byte carrying out_sop.
module usb_pkt_tx #(
    parameter int MAX_LEN = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_pid,
    input  logic [$clog2(MAX_LEN):0]   req_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       busy,
    output logic                       tx_done
);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

`ifdef USB_TX_SYNC_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    rd_data;
    logic [AW-1:0] nidx;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   remain;
    logic [AW:0]   len_clamp;
    logic          is_data;
    logic [15:0]   crc;
    logic [15:0]   crc_nxt;
    logic          adv;
    logic          accept;
    logic          take;
    logic          fin;
    logic          wr_ok;
`ifdef USB_TX_SYNC_EN
    logic [7:0]    pid_byte;
`endif

    // Reflected CRC16 (poly 0xA001), one byte LSB-first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        adv       = out_valid && out_ready;
        accept    = req_valid && req_ready;
        wr_ok     = wr_en && !busy;
        take      = adv && (remain != '0) &&
                    (((state == S_PID) && is_data) || (state == S_DATA));
        rd_addr   = take ? nidx + AW'(1) : nidx;
        crc_nxt   = crc16_upd(crc, out_data);
        len_clamp = (req_len > LEN_MAX) ? LEN_MAX : req_len;
        fin       = adv && (((state == S_PID) && !is_data) || (state == S_CRC_HI));
    end

    // Write-first buffer: rd_data always holds the next payload byte to present.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
        rd_data <= (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            req_ready <= 1'b1;
            crc       <= 16'hFFFF;
            nidx      <= '0;
            remain    <= '0;
            is_data   <= 1'b0;
`ifdef USB_TX_SYNC_EN
            pid_byte  <= 8'h00;
`endif
        end else begin
            tx_done <= 1'b0;
            nidx    <= (state == S_IDLE) ? '0 : rd_addr;
            if (adv)
                out_sop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_data   <= (req_pid[1:0] == 2'b11);
                        remain    <= len_clamp;
                        crc       <= 16'hFFFF;
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
`ifdef USB_TX_SYNC_EN
                        pid_byte  <= {~req_pid, req_pid};
                        state     <= S_SYNC;
                        out_data  <= 8'h80;
                        out_eop   <= 1'b0;
`else
                        state     <= S_PID;
                        out_data  <= {~req_pid, req_pid};
                        out_eop   <= (req_pid[1:0] != 2'b11);
`endif
                    end
                end
`ifdef USB_TX_SYNC_EN
                S_SYNC: begin
                    if (adv) begin
                        state    <= S_PID;
                        out_data <= pid_byte;
                        out_eop  <= !is_data;
                    end
                end
`endif
                S_PID: begin
                    if (adv && is_data) begin
                        if (remain != '0) begin
                            state    <= S_DATA;
                            out_data <= rd_data;
                            remain   <= remain - (AW+1)'(1);
                        end else begin
                            state    <= S_CRC_LO;
                            out_data <= ~crc[7:0];
                        end
                    end
                end
                // CRC folds in each payload byte only as the sink takes it.
                S_DATA: begin
                    if (adv) begin
                        crc <= crc_nxt;
                        if (remain != '0) begin
                            out_data <= rd_data;
                            remain   <= remain - (AW+1)'(1);
                        end else begin
                            state    <= S_CRC_LO;
                            out_data <= ~crc_nxt[7:0];
                        end
                    end
                end
                S_CRC_LO: begin
                    if (adv) begin
                        state    <= S_CRC_HI;
                        out_data <= ~crc[15:8];
                        out_eop  <= 1'b1;
                    end
                end
                S_CRC_HI: ;
                default: state <= S_IDLE;
            endcase
            if (fin) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_data  <= 8'h00;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
                busy      <= 1'b0;
                req_ready <= 1'b1;
                tx_done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_tx.sv
// Bench for usb_pkt_tx: packet-level reference model, per-cycle scoreboard, directed packets.
module tb_usb_pkt_tx;
    localparam int MAX_LEN = 64;
    localparam int AW = 6;
`ifdef USB_TX_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_pid;
    logic [AW:0]   req_len;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_sop;
    logic          out_eop;
    logic          busy;
    logic          tx_done;

    usb_pkt_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_pid(req_pid), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] bmem [MAX_LEN];
    exp_t       expq [$];
    logic [7:0] cap [$];
    bit         rnd_ready = 1'b0;
    bit         mbusy = 1'b0;
    logic [7:0] desc [18] = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34,
                              8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Bit-serial USB CRC16 register step, one data bit at a time.
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    // Expected line bytes for one request; returns the byte count.
    function automatic int push_pkt(input logic [3:0] pid, input int len);
        int         l;
        int         n;
        bit         dp;
        logic [15:0] c;
        l  = (len > MAX_LEN) ? MAX_LEN : len;
        dp = (pid[1:0] == 2'b11);
        n  = 0;
        c  = 16'hFFFF;
        if (SYNC != 0) begin
            expq.push_back('{8'h80, 1'b1, 1'b0});
            n++;
        end
        expq.push_back('{{~pid, pid}, 1'(SYNC == 0), !dp});
        n++;
        if (dp) begin
            for (int i = 0; i < l; i++) begin
                expq.push_back('{bmem[i], 1'b0, 1'b0});
                c = crc_bit(c, bmem[i]);
                n++;
            end
            c = ~c;
            expq.push_back('{c[7:0], 1'b0, 1'b0});
            expq.push_back('{c[15:8], 1'b0, 1'b1});
            n += 2;
        end
        return n;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Scoreboard: every cycle, check handshake bytes, stall stability, tx_done and busy.
    initial begin
        logic [7:0] pd;
        logic       ps, pe, pv, pr, eop_prev;
        exp_t       e;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; ps = 1'b0; pe = 1'b0; eop_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                eop_prev = 1'b0;
                mbusy = 1'b0;
            end else begin
                check("tx_done", tx_done, eop_prev);
                check("busy", busy, mbusy);
                check("req_ready", req_ready, !mbusy);
                if (pv && !pr) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, pd);
                    check("stall_sop", out_sop, ps);
                    check("stall_eop", out_eop, pe);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %0h, want no byte", out_data);
                    end else begin
                        e = expq.pop_front();
                        check("byte", out_data, e.d);
                        check("sop", out_sop, e.s);
                        check("eop", out_eop, e.e);
                    end
                    cap.push_back(out_data);
                end
                eop_prev = out_valid && out_ready && out_eop;
                if (eop_prev) mbusy = 1'b0;
                pv = out_valid; pr = out_ready; pd = out_data; ps = out_sop; pe = out_eop;
            end
        end
    end

    task automatic load(input int n, input bit pattern);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = pattern ? 8'(i * 7 + 3) : desc[i];
            bmem[i] = wr_data;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic request(input logic [3:0] pid, input int len);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_pid   = pid;
        req_len   = len[AW:0];
        @(negedge clk);
        check("req_ready_at_req", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mbusy     = 1'b1;
    endtask

    task automatic send(input logic [3:0] pid, input int len, input bit mid_wr);
        int nb;
        int c;
        bit done;
        cap.delete();
        nb = push_pkt(pid, len);
        request(pid, len);
        done = 1'b0;
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1) check("first_byte_latency", out_valid, 1);
            if (mid_wr) begin
                wr_en   = (c <= 4);
                wr_addr = AW'(c + 9);
                wr_data = 8'hEE;
            end
            if (tx_done) done = 1'b1;
        end
        wr_en = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_done_timeout: got no tx_done in %0d cycles, want one", c);
        end else if (!rnd_ready) begin
            check("packet_cycles", c, nb + 1);
        end
        check("queue_drained", expq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 8'h00);
        check({tag, "_sop"}, out_sop, 0);
        check({tag, "_eop"}, out_eop, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tx_done"}, tx_done, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        logic [15:0] r;
        int          nb;
        rst_n = 1'b0; req_valid = 1'b0; req_pid = 4'h0; req_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        send(4'h2, 0, 1'b0);
        check("ack_count", cap.size(), 1 + SYNC);
        check("ack_first", cap[0], (SYNC != 0) ? 8'h80 : 8'hD2);
        check("ack_pid", cap[SYNC], 8'hD2);

        send(4'hE, 5, 1'b0);
        check("stall_count", cap.size(), 1 + SYNC);
        check("stall_pid", cap[SYNC], 8'h1E);

        send(4'h3, 0, 1'b0);
        check("zlp_count", cap.size(), 3 + SYNC);
        check("zlp_pid", cap[SYNC], 8'hC3);
        check("zlp_crc_lo", cap[SYNC + 1], 8'h00);
        check("zlp_crc_hi", cap[SYNC + 2], 8'h00);

        load(18, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            rnd_ready = (pass == 1);
            send(4'hB, 18, 1'b0);
            check("desc_count", cap.size(), 21 + SYNC);
            check("desc_pid", cap[SYNC], 8'h4B);
            check("desc_first", cap[SYNC + 1], 8'h12);
            check("desc_last", cap[SYNC + 18], 8'h01);
            r = 16'hFFFF;
            for (int i = 1; i <= 20; i++) r = crc_bit(r, cap[SYNC + i]);
            check("desc_residual", r, 16'hB001);
        end
        rnd_ready = 1'b0;

        load(64, 1'b1);
        send(4'h3, 100, 1'b1);
        check("clamp_count", cap.size(), 67 + SYNC);
        send(4'hB, 16, 1'b0);
        check("frozen_byte10", cap[SYNC + 11], 8'h49);

        // Abort while payload byte 5 is on the line.
        cap.delete();
        nb = push_pkt(4'hB, 18);
        request(4'hB, 18);
        repeat (7 + SYNC) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_seen", cap.size(), 7 + SYNC);
        expq.delete();
        mbusy = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        send(4'h2, 0, 1'b0);
        check("post_ack_count", cap.size(), 1 + SYNC);
        check("post_ack_first", cap[0], (SYNC != 0) ? 8'h80 : 8'hD2);
        send(4'h3, 4, 1'b0);
        check("persist_byte0", cap[SYNC + 1], 8'h03);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
